// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: RAM port status codes and the memory arbiter state encoding.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side request/response signals and the shared RAM port, bundled for the arbiter.
interface mem_arbiter_if
  import cpu_types_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              iREN;
  logic [ADDR_W-1:0] iaddr;
  logic              iwait;
  logic [DATA_W-1:0] iload;
  logic              dREN;
  logic              dWEN;
  logic [ADDR_W-1:0] daddr;
  logic [DATA_W-1:0] dstore;
  logic              dwait;
  logic [DATA_W-1:0] dload;
  logic              ramREN;
  logic              ramWEN;
  logic [ADDR_W-1:0] ramaddr;
  logic [DATA_W-1:0] ramstore;
  logic [DATA_W-1:0] ramload;
  ramstate_t         ramstate;

  // Arbiter side: consumes cache requests and RAM status, drives waits and RAM strobes.
  modport master (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  // Environment side: caches and RAM.
  modport slave (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates instruction- and data-cache requests onto one RAM port with alternating
// priority; completion (wait low) is combinational on the RAM ACCESS cycle.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 CLK,
  input  logic                 nRST,
  mem_arbiter_if.master        bus,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  arb_state_t state, next_state;
  logic       last_d;
  logic       dreq;
  logic       done_i, done_d, err_hit;

  assign dreq      = bus.dREN | bus.dWEN;
  assign bus.iload = bus.ramload;
  assign bus.dload = bus.ramload;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= IDLE;
      last_d  <= 1'b0;
      err_cnt <= '0;
    end else begin
      state <= next_state;
      if (done_i)      last_d <= 1'b0;
      else if (done_d) last_d <= 1'b1;
      if (err_hit && (err_cnt != {ERR_CNT_W{1'b1}})) err_cnt <= err_cnt + 1'b1;
    end
  end

  // Strobes are decoded from state, so the async reset forcing IDLE drops them at once.
  always_comb begin
    next_state   = state;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    bus.iwait    = 1'b1;
    bus.dwait    = 1'b1;
    done_i       = 1'b0;
    done_d       = 1'b0;
    err_hit      = 1'b0;
    case (state)
      IDLE: begin
        if (dreq && bus.iREN && last_d) next_state = SERVE_I;
        else if (dreq)                  next_state = SERVE_D;
        else if (bus.iREN)              next_state = SERVE_I;
      end
      SERVE_I: begin
        bus.ramREN  = bus.iREN;
        bus.ramaddr = bus.iaddr;
        if (!bus.iREN) begin
          next_state = IDLE;
        end else if (bus.ramstate == ACCESS) begin
          bus.iwait  = 1'b0;
          done_i     = 1'b1;
          next_state = IDLE;
        end else if (bus.ramstate == ERROR) begin
          err_hit = 1'b1;
        end
      end
      SERVE_D: begin
        bus.ramaddr  = bus.daddr;
        bus.ramstore = bus.dstore;
        bus.ramWEN   = bus.dWEN;
        bus.ramREN   = bus.dREN & ~bus.dWEN;
        if (!dreq) begin
          next_state = IDLE;
        end else if (bus.ramstate == ACCESS) begin
          bus.dwait  = 1'b0;
          done_d     = 1'b1;
          next_state = IDLE;
        end else if (bus.ramstate == ERROR) begin
          err_hit = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: completions are matched against a queue of expected grants.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  typedef struct {
    bit          is_d;
    bit          wen;
    logic [31:0] addr;
    logic [31:0] store;
    logic [31:0] load;
  } exp_t;

  logic       CLK = 1'b0;
  logic       nRST;
  logic [7:0] err_cnt;
  int         errors = 0;
  int         checks = 0;
  exp_t       sb[$];

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .CLK    (CLK),
    .nRST   (nRST),
    .bus    (bus),
    .err_cnt(err_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input bit is_d, input bit wen, input logic [31:0] addr,
                      input logic [31:0] store, input logic [31:0] load);
    exp_t e;
    e.is_d = is_d; e.wen = wen; e.addr = addr; e.store = store; e.load = load;
    sb.push_back(e);
  endtask

  // Completion monitor: any cycle with a wait low must match the oldest expected grant.
  always @(negedge CLK) begin
    exp_t e;
    if (nRST === 1'b1 && (bus.iwait === 1'b0 || bus.dwait === 1'b0)) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", {62'd0, bus.iwait, bus.dwait}, 64'b11);
      end else begin
        e = sb.pop_front();
        chk("done_client", {62'd0, bus.iwait, bus.dwait}, e.is_d ? 64'b10 : 64'b01);
        chk("done_addr", 64'(bus.ramaddr), 64'(e.addr));
        chk("done_load", e.is_d ? 64'(bus.dload) : 64'(bus.iload), 64'(e.load));
        if (e.is_d && e.wen) chk("done_wdata", 64'(bus.ramstore), 64'(e.store));
      end
    end
  end

  // Single-client transaction starting in an IDLE cycle; ends in the following IDLE cycle.
  task automatic txn(input bit is_d, input bit ren, input bit wen, input logic [31:0] addr,
                     input logic [31:0] store, input logic [31:0] load,
                     input int nbusy, input int nerr);
    push(is_d, wen, addr, store, load);
    if (is_d) begin
      bus.dREN = ren; bus.dWEN = wen; bus.daddr = addr; bus.dstore = store;
    end else begin
      bus.iREN = 1'b1; bus.iaddr = addr;
    end
    bus.ramstate = FREE;
    step();
    for (int i = 0; i < nbusy + nerr; i++) begin
      bus.ramstate = (i < nerr) ? ERROR : BUSY;
      @(negedge CLK);
      chk("srv_addr", 64'(bus.ramaddr), 64'(addr));
      if (is_d) begin
        chk("srv_wen", 64'(bus.ramWEN), 64'(wen));
        chk("srv_ren", 64'(bus.ramREN), 64'(ren & ~wen));
        chk("srv_store", 64'(bus.ramstore), 64'(store));
        chk("srv_dwait", 64'(bus.dwait), 64'd1);
      end else begin
        chk("srv_ren", 64'(bus.ramREN), 64'd1);
        chk("srv_wen", 64'(bus.ramWEN), 64'd0);
        chk("srv_iwait", 64'(bus.iwait), 64'd1);
      end
      step();
    end
    bus.ramstate = ACCESS;
    bus.ramload  = load;
    step();
    bus.iREN = 1'b0; bus.dREN = 1'b0; bus.dWEN = 1'b0;
    bus.ramstate = FREE;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int ist, dst, imax, dmax;
    nRST = 1'b0;
    bus.iREN = 1'b1; bus.iaddr = 32'h0; bus.dREN = 1'b0; bus.dWEN = 1'b1;
    bus.daddr = 32'h100; bus.dstore = 32'h55; bus.ramstate = FREE; bus.ramload = 32'h0;

    // Reset with both requests asserted
    step(); step();
    @(negedge CLK);
    chk("rst_ramREN", 64'(bus.ramREN), 64'd0);
    chk("rst_ramWEN", 64'(bus.ramWEN), 64'd0);
    chk("rst_ramaddr", 64'(bus.ramaddr), 64'd0);
    chk("rst_ramstore", 64'(bus.ramstore), 64'd0);
    chk("rst_iwait", 64'(bus.iwait), 64'd1);
    chk("rst_dwait", 64'(bus.dwait), 64'd1);
    chk("rst_err_cnt", 64'(err_cnt), 64'd0);
    step();
    nRST = 1'b1;
    push(1'b1, 1'b1, 32'h100, 32'h55, 32'h1234);
    @(negedge CLK);
    chk("idle_no_strobe", 64'({bus.ramREN, bus.ramWEN}), 64'd0);
    step();
    @(negedge CLK);
    chk("first_grant_wen", 64'(bus.ramWEN), 64'd1);
    chk("first_grant_addr", 64'(bus.ramaddr), 64'h100);
    step();
    bus.ramstate = ACCESS; bus.ramload = 32'h1234;
    step();
    bus.iREN = 1'b0; bus.dWEN = 1'b0; bus.ramstate = FREE;

    // Data write, one BUSY; data read with three ERROR cycles
    txn(1'b1, 1'b0, 1'b1, 32'h100, 32'hDEAD_BEEF, 32'h0, 1, 0);
    txn(1'b1, 1'b1, 1'b0, 32'h200, 32'h0, 32'hCAFE_0001, 0, 3);
    @(negedge CLK);
    chk("err_cnt_3", 64'(err_cnt), 64'd3);

    // ERROR while idle is ignored
    step();
    bus.ramstate = ERROR;
    step(); step();
    @(negedge CLK);
    chk("idle_error_ignored", 64'(err_cnt), 64'd3);
    step();

    // Instruction fetch with two BUSY cycles
    txn(1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 32'h2001_0005, 2, 0);

    // Both clients held: grants alternate D, I, D, I
    bus.iREN = 1'b1; bus.dREN = 1'b1; bus.iaddr = 32'h80; bus.daddr = 32'h180;
    for (int k = 0; k < 4; k++)
      push(k % 2 == 0, 1'b0, (k % 2 == 0) ? 32'h180 : 32'h80, 32'h0, 32'h1000 + k);
    ist = 0; dst = 0; imax = 0; dmax = 0;
    for (int k = 0; k < 4; k++) begin
      for (int ph = 0; ph < 3; ph++) begin
        bus.ramstate = (ph == 0) ? FREE : (ph == 1) ? BUSY : ACCESS;
        bus.ramload  = 32'h1000 + k;
        @(negedge CLK);
        ist = bus.iwait ? ist + 1 : 0;
        dst = bus.dwait ? dst + 1 : 0;
        if (ist > imax) imax = ist;
        if (dst > dmax) dmax = dst;
        step();
      end
    end
    bus.iREN = 1'b0; bus.dREN = 1'b0; bus.ramstate = FREE;
    chk("iwait_max_streak", 64'(imax), 64'd5);
    chk("dwait_max_streak", 64'(dmax), 64'd5);

    // Data request withdrawn while served; pending fetch granted next
    bus.dREN = 1'b1; bus.daddr = 32'h1C0; bus.iREN = 1'b1; bus.iaddr = 32'hC0;
    bus.ramstate = BUSY;
    step();
    @(negedge CLK);
    chk("wd_ren_before", 64'(bus.ramREN), 64'd1);
    chk("wd_addr", 64'(bus.ramaddr), 64'h1C0);
    step();
    bus.dREN = 1'b0;
    @(negedge CLK);
    chk("wd_ren_dropped", 64'(bus.ramREN), 64'd0);
    chk("wd_dwait", 64'(bus.dwait), 64'd1);
    push(1'b0, 1'b0, 32'hC0, 32'h0, 32'h77);
    step();
    @(negedge CLK);
    chk("wd_idle_addr", 64'(bus.ramaddr), 64'd0);
    chk("wd_idle_ren", 64'(bus.ramREN), 64'd0);
    step();
    bus.ramstate = ACCESS; bus.ramload = 32'h77;
    @(negedge CLK);
    chk("wd_i_granted", 64'(bus.ramREN), 64'd1);
    step();
    bus.iREN = 1'b0; bus.ramstate = FREE;

    // Error counter saturation
    txn(1'b1, 1'b1, 1'b0, 32'h300, 32'h0, 32'hABCD, 0, 300);
    @(negedge CLK);
    chk("err_cnt_sat", 64'(err_cnt), 64'd255);

    // Reset asserted mid-SERVE_I
    step();
    bus.iREN = 1'b1; bus.iaddr = 32'hE0; bus.ramstate = BUSY;
    step();
    #2;
    chk("mid_ren_before", 64'(bus.ramREN), 64'd1);
    nRST = 1'b0;
    #1;
    chk("mid_rst_ren", 64'(bus.ramREN), 64'd0);
    chk("mid_rst_addr", 64'(bus.ramaddr), 64'd0);
    chk("mid_rst_iwait", 64'(bus.iwait), 64'd1);
    chk("mid_rst_err_cnt", 64'(err_cnt), 64'd0);
    step();
    bus.iREN = 1'b0; bus.ramstate = FREE; nRST = 1'b1;
    step();
    @(negedge CLK);
    chk("post_rst_idle", 64'({bus.ramREN, bus.ramWEN}), 64'd0);

    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sits directly downstream of the instruction cache and the data cache. It arbitrates their miss and writeback requests onto the single shared RAM port.
- It returns load data and per-client wait signals. The instruction cache is released on the same cycle RAM reports ACCESS.
- Registered three-state FSM with alternating priority, so instruction fetch cannot be starved by a stream of data traffic.

Parameters:
- ADDR_W, 32, address width of iaddr/daddr/ramaddr
- DATA_W, 32, data word width
- ERR_CNT_W, 8, width of saturating RAM-error counter

Ports:
- CLK  in  1  system clock, rising edge
- nRST  in  1  reset; asynchronous, active-low
- iREN  in  1  instruction read request from instruction cache
- iaddr  in  ADDR_W  instruction read address
- iwait  out  1  1 = instruction request not complete
- iload  out  DATA_W  instruction read data, valid when iwait=0
- dREN  in  1  data read request
- dWEN  in  1  data write request
- daddr  in  ADDR_W  data address
- dstore  in  DATA_W  data write value
- dwait  out  1  1 = data request not complete
- dload  out  DATA_W  data read data, valid when dwait=0
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  ADDR_W  RAM address
- ramstore  out  DATA_W  RAM write data
- ramload  in  DATA_W  RAM read data
- ramstate  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3
- err_cnt  out  ERR_CNT_W  saturating count of ERROR cycles seen while serving

Behaviour:
- State register `state`:
  - States: IDLE, SERVE_I, SERVE_D.
  - `last_d` (1 = last completed grant was data).
  - `err_cnt`.
- Reset (async, nRST=0): state=IDLE, last_d=0, err_cnt=0. Outputs respond immediately:
  - ramREN=0, ramWEN=0, ramaddr=0, ramstore=0.
  - iwait=1, dwait=1.
- Reset mid-transaction aborts it. RAM strobes drop with nRST, not at the next edge.
- IDLE, next-state selection (dreq = dREN|dWEN):
  - dreq & iREN & last_d: go to SERVE_I.
  - dreq otherwise: go to SERVE_D.
  - iREN only: go to SERVE_I.
  - No request: stay in IDLE.
  - No RAM strobes are driven in IDLE, so arbitration costs one cycle.
- SERVE_I:
  - Outputs: ramREN=iREN, ramWEN=0, ramaddr=iaddr.
  - When ramstate==ACCESS: iwait=0 (combinational, same cycle), iload=ramload, next state=IDLE, last_d<=0.
- SERVE_D:
  - Outputs: ramaddr=daddr, ramstore=dstore, ramWEN=dWEN, ramREN=dREN & ~dWEN. Write wins if both are asserted.
  - When ramstate==ACCESS: dwait=0, dload=ramload, next state=IDLE, last_d<=1.
- iwait=1 and dwait=1 in every other state/cycle combination. iload and dload are passed through from ramload unconditionally.
- Request withdrawn while served: the client drops its REN/WEN before ACCESS. The strobes fall the same cycle, next state=IDLE, and last_d is unchanged.
- Clients must hold address, data and strobe stable until their wait deasserts. The arbiter does not latch them.
- ERROR in SERVE_I/SERVE_D:
  - err_cnt increments and saturates at all-ones.
  - The wait stays 1 and the state is unchanged, so the request is retried while the strobe is held.
  - ERROR in IDLE is ignored.
- FREE/BUSY while serving: hold state, wait=1.
- Throughput: an ACCESS on cycle N allows a new grant at edge N+1 and new RAM strobes on cycle N+2.

Decomposition:
- Shared package cpu_types_pkg gains:
  - ramstate_t (FREE, BUSY, ACCESS, ERROR), if not already present.
  - arb_state_t (IDLE, SERVE_I, SERVE_D).
- Everything else stays local. The block is one module with no natural sub-module.
- The err_cnt saturating counter is small and stays inline.

Test Plan:
- Reset with iREN=1, dWEN=1 asserted -> ramREN=ramWEN=0, iwait=dwait=1, err_cnt=0. After release, the first grant is SERVE_D (last_d=0).
- iREN=1, iaddr=0x0000_0040. RAM returns BUSY x2, then ACCESS with ramload=0x2001_0005 -> ramREN=1 and ramaddr=0x40 from cycle 2. iwait=0 and iload=0x2001_0005 exactly on the ACCESS cycle; IDLE next.
- dWEN=1, daddr=0x0000_0100, dstore=0xDEAD_BEEF; one BUSY then ACCESS -> ramWEN=1, ramREN=0, ramstore=0xDEADBEEF. dwait=0 on ACCESS only.
- iREN and dREN held continuously, RAM always ACCESS on the 2nd serve cycle -> grants alternate D, I, D, I; neither wait stays high for more than 5 consecutive cycles.
- SERVE_D with ramstate=ERROR for 3 cycles, then ACCESS -> err_cnt=3, dwait=1 during ERROR, completes on ACCESS. With 300 ERROR cycles forced, err_cnt saturates at 255.
- dREN dropped while in SERVE_D before ACCESS -> ramREN=0 the same cycle, state IDLE next, a pending iREN is granted next. Separately, nRST asserted mid-SERVE_I -> strobes drop immediately.
